md_ctrl: RTL and testbench
==========================

// Module: md_ctrl
// PURPOSE
//   E-stage multiply/divide sequencer. Owns HI/LO; accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo
//   from the E-stage instruction and holds the result for a fixed latency (busy window).
//   Raises Stall so the D-stage MD-class instruction waits until the unit is idle.
//   Sits beside E_ALU. Drives the hilo value into the M pipeline register.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   Clk      in   1   clock, rising edge
//   Reset    in   1   asynchronous, active-low reset
//   Valid    in   1   E-stage slot holds a real instruction (0 = bubble)
//   MDType   in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo; others = none
//   A        in   32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
//   B        in   32  forwarded rt value (divisor / multiplier)
//   DUseMD   in   1   D-stage instruction is MD-class (MDType 1..8)
//   Start    out  1   op 1..4 accepted this cycle
//   Busy     out  1   operation in flight
//   Stall    out  1   hold F/D, insert bubble into E
//   HiloOut  out  32  mfhi -> HI, mflo -> LO, else 0
//   HI, LO   out  32  architectural registers
// BEHAVIOUR
//   Reset low: state IDLE, counter 0, HI = LO = 0, pending = 0. Busy = 0. Start, Stall and HiloOut forced 0.
//   States: IDLE, BUSY. Counter is 4 bits wide.
//   Start  = Reset & Valid & state==IDLE & MDType in 1..4 (combinational).
//   IDLE --Start--> BUSY: at the edge, the counter loads N (MULT_CYCLES or DIV_CYCLES).
//     At the same edge, pendHI/pendLO load the full result computed from A and B.
//   BUSY: the counter decrements at every edge. At the edge where counter==1:
//     HI <= pendHI, LO <= pendLO, state returns to IDLE.
//   Timing: Start in cycle t, Busy = 1 in cycles t+1..t+N, new HI/LO visible from cycle t+N+1.
//   Busy = (state==BUSY), registered.
//   Stall = DUseMD & (Start | Busy). Stall is never driven by non-MD instructions.
//   mult/multu: {HI,LO} = 64-bit signed/unsigned product of A and B.
//   div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//     0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
//   divu: LO = A/B, HI = A%B, both unsigned.
//   Divide by zero (B==0): pending = current HI/LO, so HI/LO are unchanged.
//     The full DIV_CYCLES busy window still runs.
//   mthi/mtlo: when Valid & IDLE, HI or LO <= A at the edge. Readable next cycle.
//   mfhi/mflo: HiloOut is combinational from the current HI/LO registers. No result bypass.
//   MDType 1..8 arriving while BUSY is unreachable by construction because of Stall.
//     If it occurs anyway, it is ignored: no Start, no HI/LO write, and the counter is undisturbed.
//   Valid=0: no action. Busy and the counter keep running.
//   Reset asserted mid-operation: the in-flight result is discarded and HI/LO are cleared immediately.
// TESTING
//   Sequence: mult, A=3, B=0xFFFFFFFE.
//     Start=1 for 1 cycle, then Busy=1 for 5 cycles.
//     Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   Sequence: divu, A=7, B=2.
//     Busy=1 for 10 cycles.
//     Then LO=3, HI=1.
//   Sequence: div, A=0xFFFFFFF9, B=2.
//     Result: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     Repeat with A=0x80000000, B=0xFFFFFFFF.
//     Result: LO=0x80000000, HI=0.
//   Sequence: mthi A=0x1234, then mtlo A=0x5678, then div B=0.
//     Busy=1 for 10 cycles.
//     HI=0x1234 and LO=0x5678 are unchanged.
//     mfhi then gives HiloOut=0x1234.
//   Sequence: mult with DUseMD=1 held.
//     Stall=1 for 6 cycles (t..t+5).
//     Repeat with DUseMD=0: Stall stays 0.
//     Inject MDType=7 while BUSY: no HI change.
//   Sequence: mult; pull Reset low in the 3rd Busy cycle.
//     Busy, HI and LO go to 0 immediately.
//     After release, an mflo returns HiloOut=0.

Source files
------------

// File: rtl/md_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO.
// Results are computed at issue and committed after a fixed busy window.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Valid,
   input  logic [3:0]  MDType,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        DUseMD,
   output logic        Start,
   output logic        Busy,
   output logic        Stall,
   output logic [31:0] HiloOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] phi_q, phi_d;
   logic [31:0] plo_q, plo_d;

   logic op_mult, op_multu, op_div, op_divu;
   logic op_mfhi, op_mflo, op_mthi, op_mtlo;
   logic md_op, is_mul;

   always_comb begin
      op_mult  = 1'b0;
      op_multu = 1'b0;
      op_div   = 1'b0;
      op_divu  = 1'b0;
      op_mfhi  = 1'b0;
      op_mflo  = 1'b0;
      op_mthi  = 1'b0;
      op_mtlo  = 1'b0;
      unique case (MDType)
         4'd1:    op_mult  = 1'b1;
         4'd2:    op_multu = 1'b1;
         4'd3:    op_div   = 1'b1;
         4'd4:    op_divu  = 1'b1;
         4'd5:    op_mfhi  = 1'b1;
         4'd6:    op_mflo  = 1'b1;
         4'd7:    op_mthi  = 1'b1;
         4'd8:    op_mtlo  = 1'b1;
         default: ;
      endcase
   end

   assign md_op  = op_mult | op_multu | op_div | op_divu;
   assign is_mul = op_mult | op_multu;

   // Signed product via sign-extended operands; low 64 bits are exact.
   logic [63:0] prod_s, prod_u;
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly.
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quo_s, rem_s;
   logic [31:0] quo_u, rem_u;
   logic        b_zero;

   assign b_zero = (B == 32'd0);
   assign a_mag  = A[31] ? (~A + 32'd1) : A;
   assign b_mag  = B[31] ? (~B + 32'd1) : B;
   assign q_mag  = b_zero ? 32'd0 : a_mag / b_mag;
   assign r_mag  = b_zero ? 32'd0 : a_mag % b_mag;
   assign quo_s  = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
   assign rem_s  = A[31] ? (~r_mag + 32'd1) : r_mag;
   assign quo_u  = b_zero ? 32'd0 : A / B;
   assign rem_u  = b_zero ? 32'd0 : A % B;

   logic [31:0] res_hi, res_lo;

   always_comb begin
      res_hi = hi_q;
      res_lo = lo_q;
      if (op_mult) begin
         res_hi = prod_s[63:32];
         res_lo = prod_s[31:0];
      end else if (op_multu) begin
         res_hi = prod_u[63:32];
         res_lo = prod_u[31:0];
      end else if (op_div && !b_zero) begin
         res_hi = rem_s;
         res_lo = quo_s;
      end else if (op_divu && !b_zero) begin
         res_hi = rem_u;
         res_lo = quo_u;
      end
   end

   assign Start = Reset & Valid & (state_q == IDLE) & md_op;
   assign Busy  = (state_q == BUSY);
   assign Stall = DUseMD & (Start | Busy);

   always_comb begin
      HiloOut = 32'd0;
      if (Reset && op_mfhi) HiloOut = hi_q;
      if (Reset && op_mflo) HiloOut = lo_q;
   end

   assign HI = hi_q;
   assign LO = lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      unique case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = BUSY;
               cnt_d   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
               phi_d   = res_hi;
               plo_d   = res_lo;
            end else if (Valid && op_mthi) begin
               hi_d = A;
            end else if (Valid && op_mtlo) begin
               lo_d = A;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_d    = phi_q;
               lo_d    = plo_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         phi_q   <= 32'd0;
         plo_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: latency, results, stall and reset.
// Expected values are hand-computed constants.
module tb_md_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Valid;
   logic [3:0]  MDType;
   logic [31:0] A, B;
   logic        DUseMD;
   logic        Start, Busy, Stall;
   logic [31:0] HiloOut, HI, LO;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .MDType(MDType),
      .A(A), .B(B), .DUseMD(DUseMD), .Start(Start), .Busy(Busy),
      .Stall(Stall), .HiloOut(HiloOut), .HI(HI), .LO(LO)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] t,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic du);
      Valid  = v;
      MDType = t;
      A      = a;
      B      = b;
      DUseMD = du;
      #1;
   endtask

   task automatic idle_in();
      drive(1'b0, 4'd0, 32'd0, 32'd0, DUseMD);
   endtask

   task automatic busy_run(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_busy"}, 32'(Busy), 32'd1);
         tick();
      end
      chk({tag, "_done"}, 32'(Busy), 32'd0);
   endtask

   initial begin
      Reset = 1'b0;
      drive(1'b1, 4'd1, 32'd3, 32'd4, 1'b1);
      chk("rst_start", 32'(Start), 32'd0);
      chk("rst_stall", 32'(Stall), 32'd0);
      tick();
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
      chk("rst_hilo", HiloOut, 32'd0);
      Reset = 1'b1;
      idle_in();
      tick();

      // mult 3 * -2
      drive(1'b1, 4'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
      chk("mult_start", 32'(Start), 32'd1);
      chk("mult_stall", 32'(Stall), 32'd0);
      tick();
      idle_in();
      chk("mult_start1", 32'(Start), 32'd0);
      busy_run("mult", 5);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFA);

      // divu 7 / 2
      drive(1'b1, 4'd4, 32'd7, 32'd2, 1'b0);
      chk("divu_start", 32'(Start), 32'd1);
      tick();
      idle_in();
      chk("divu_hold_hi", HI, 32'hFFFF_FFFF);
      busy_run("divu", 10);
      chk("divu_lo", LO, 32'd3);
      chk("divu_hi", HI, 32'd1);

      // div -7 / 2
      drive(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
      tick();
      idle_in();
      busy_run("div1", 10);
      chk("div1_lo", LO, 32'hFFFF_FFFD);
      chk("div1_hi", HI, 32'hFFFF_FFFF);

      // div overflow case
      drive(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      tick();
      idle_in();
      busy_run("div2", 10);
      chk("div2_lo", LO, 32'h8000_0000);
      chk("div2_hi", HI, 32'd0);

      // mthi / mtlo then divide by zero
      drive(1'b1, 4'd7, 32'h1234, 32'd0, 1'b0);
      chk("mthi_start", 32'(Start), 32'd0);
      tick();
      chk("mthi_hi", HI, 32'h1234);
      drive(1'b1, 4'd8, 32'h5678, 32'd0, 1'b0);
      tick();
      chk("mtlo_lo", LO, 32'h5678);
      drive(1'b1, 4'd3, 32'd99, 32'd0, 1'b0);
      chk("dz_start", 32'(Start), 32'd1);
      tick();
      idle_in();
      busy_run("dz", 10);
      chk("dz_hi", HI, 32'h1234);
      chk("dz_lo", LO, 32'h5678);
      drive(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
      chk("mfhi", HiloOut, 32'h1234);
      drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
      chk("mflo", HiloOut, 32'h5678);
      drive(1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
      chk("mfnone", HiloOut, 32'd0);

      // stall with DUseMD held, 0x10000 squared
      drive(1'b1, 4'd1, 32'h1_0000, 32'h1_0000, 1'b1);
      chk("stl_t0", 32'(Stall), 32'd1);
      tick();
      idle_in();
      for (int i = 0; i < 5; i++) begin
         chk("stl_busy", 32'(Stall), 32'd1);
         tick();
      end
      chk("stl_end", 32'(Stall), 32'd0);
      chk("stl_hi", HI, 32'd1);
      chk("stl_lo", LO, 32'd0);

      // DUseMD low, inject ops while busy
      drive(1'b1, 4'd1, 32'd2, 32'd3, 1'b0);
      chk("nst_t0", 32'(Stall), 32'd0);
      chk("nst_start", 32'(Start), 32'd1);
      tick();
      for (int i = 0; i < 5; i++) begin
         if (i == 1) drive(1'b1, 4'd7, 32'hDEAD, 32'd0, 1'b0);
         else if (i == 2) drive(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
         else idle_in();
         chk("nst_stall", 32'(Stall), 32'd0);
         chk("nst_start_b", 32'(Start), 32'd0);
         chk("nst_busy", 32'(Busy), 32'd1);
         tick();
         if (i < 4) chk("inj_hi", HI, 32'd1);
      end
      idle_in();
      chk("nst_done", 32'(Busy), 32'd0);
      chk("nst_hi", HI, 32'd0);
      chk("nst_lo", LO, 32'd6);

      // reset in the 3rd busy cycle
      drive(1'b1, 4'd7, 32'hABCD, 32'd0, 1'b0);
      tick();
      chk("pre_hi", HI, 32'hABCD);
      drive(1'b1, 4'd1, 32'd5, 32'd7, 1'b0);
      tick();
      idle_in();
      tick();
      tick();
      chk("r3_busy_pre", 32'(Busy), 32'd1);
      Reset = 1'b0;
      #1;
      chk("r3_busy", 32'(Busy), 32'd0);
      chk("r3_hi", HI, 32'd0);
      chk("r3_lo", LO, 32'd0);
      tick();
      Reset = 1'b1;
      tick();
      drive(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
      chk("r3_mflo", HiloOut, 32'd0);
      idle_in();
      for (int i = 0; i < 6; i++) tick();
      chk("r3_idle", 32'(Busy), 32'd0);
      chk("r3_lo_late", LO, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
